// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared encodings, FSM states and alignment check for the load/store unit
package lsu_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_LDRSP,
        ST_MERGE,
        ST_WR,
        ST_ERR
    } lsu_state_e;

    // Size 11 is treated as misaligned so every illegal request takes the same error path.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SZ_B:    misaligned = 1'b0;
            SZ_H:    misaligned = addr_lo[0];
            SZ_W:    misaligned = (addr_lo != 2'b00);
            default: misaligned = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane.sv
// rtl/lsu_lane.sv - byte/half lane extract-extend for loads and lane merge for stores
module lsu_lane
    import lsu_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    output logic [31:0] ld_data,
    output logic [31:0] st_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed lane, extend it for loads, and splice store data into the read word.
    always_comb begin
        byte_sel = rdata[{addr_lo, 3'b000} +: 8];
        half_sel = rdata[{addr_lo[1], 4'b0000} +: 16];

        case (size)
            SZ_B:    ld_data = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
            SZ_H:    ld_data = {{16{~is_unsigned & half_sel[15]}}, half_sel};
            default: ld_data = rdata;
        endcase

        st_data = rdata;
        case (size)
            SZ_B:    st_data[{addr_lo, 3'b000} +: 8]     = wdata[7:0];
            SZ_H:    st_data[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
            default: st_data = wdata;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - load/store sequencer for a word-only synchronous-read data memory
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata
);

    lsu_state_e        state_q, state_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              unsigned_q, unsigned_d;
    logic [1:0]        addr_lo_q, addr_lo_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_we_q, mem_we_d;
    logic              mem_re_q, mem_re_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;
    logic              req_ready_q, req_ready_d;
    logic [DATA_W-1:0] ld_data;
    logic [DATA_W-1:0] st_data;

    lsu_lane u_lane (
        .addr_lo     (addr_lo_q),
        .size        (size_q),
        .is_unsigned (unsigned_q),
        .rdata       (mem_rdata),
        .wdata       (wdata_q),
        .ld_data     (ld_data),
        .st_data     (st_data)
    );

    // Next state plus next values of the strobes; strobes are computed for the state being entered
    // so that the registered outputs line up with that state's cycle.
    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        size_d      = size_q;
        unsigned_d  = unsigned_q;
        addr_lo_d   = addr_lo_q;
        wdata_d     = wdata_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = '0;
        mem_we_d    = 1'b0;
        mem_re_d    = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    we_d       = req_we;
                    size_d     = req_size;
                    unsigned_d = req_unsigned;
                    addr_lo_d  = req_addr[1:0];
                    wdata_d    = req_wdata;
                    if (misaligned(req_size, req_addr[1:0])) begin
                        state_d     = ST_ERR;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else begin
                        mem_addr_d = {req_addr[ADDR_W-1:2], 2'b00};
                        if (req_we && (req_size == SZ_W)) begin
                            state_d     = ST_WR;
                            mem_we_d    = 1'b1;
                            mem_wdata_d = req_wdata;
                            rsp_valid_d = 1'b1;
                        end else begin
                            state_d  = ST_RD;
                            mem_re_d = 1'b1;
                        end
                    end
                end
            end
            ST_RD: begin
                if (we_q) begin
                    state_d = ST_MERGE;
                end else begin
                    state_d     = ST_LDRSP;
                    rsp_valid_d = 1'b1;
                end
            end
            ST_MERGE: begin
                state_d     = ST_WR;
                mem_we_d    = 1'b1;
                mem_wdata_d = st_data;
                rsp_valid_d = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase

        req_ready_d = (state_d == ST_IDLE);
    end

    // FSM state, latched request fields and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            we_q        <= 1'b0;
            size_q      <= SZ_B;
            unsigned_q  <= 1'b0;
            addr_lo_q   <= 2'b00;
            wdata_q     <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            req_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            size_q      <= size_d;
            unsigned_q  <= unsigned_d;
            addr_lo_q   <= addr_lo_d;
            wdata_q     <= wdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            mem_re_q    <= mem_re_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            req_ready_q <= req_ready_d;
        end
    end

    // Read data only exists the cycle after mem_re, so the load result is taken straight from the
    // memory's output register during LDRSP and forced to zero elsewhere.
    assign rsp_rdata = (state_q == ST_LDRSP) ? ld_data : '0;
    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_we    = mem_we_q;
    assign mem_re    = mem_re_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb/tb_lsu_ctrl.sv - directed and random self-checking bench for lsu_ctrl
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_err, mem_we, mem_re;
    logic [31:0] rsp_rdata, mem_addr, mem_wdata;
    logic [31:0] mem_rdata = 32'h0;

    logic [31:0] mem   [0:15];
    logic [7:0]  ref_b [0:63];

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [31:0] last_rdata, last_wdata, last_waddr;
    logic        seen_we;

    always #5 clk = ~clk;

    lsu_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_we       (mem_we),
        .mem_re       (mem_re),
        .mem_rdata    (mem_rdata)
    );

    // Word memory with one-cycle registered read.
    always @(posedge clk) begin
        if (mem_re) mem_rdata <= mem[mem_addr[5:2]];
        if (mem_we) mem[mem_addr[5:2]] <= mem_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_load(input int a, input int n, input bit uns);
        logic [63:0] v;
        v = 64'd0;
        for (int i = 0; i < n; i++) v = v | (64'(ref_b[a + i]) << (8 * i));
        if (!uns && n < 4 && v[8 * n - 1]) v = v - (64'd1 << (8 * n));
        return v[31:0];
    endfunction

    function automatic logic [31:0] ref_word(input int a);
        return ref_load(a - (a % 4), 4, 1'b1);
    endfunction

    // One request from a negedge: model the expected outcome, issue it, observe four cycles.
    task automatic do_req(input bit we, input logic [1:0] sz, input bit uns,
                          input logic [5:0] a6, input logic [31:0] wd);
        int          a, n, exp_lat, exp_re, exp_we;
        int          lat, extra, re_cnt, we_cnt, both, idle_nz;
        bit          err;
        logic [31:0] exp_rd, exp_wd, got_rd, got_wd, got_wa, got_ra;
        logic        got_err, rdy_at_rsp, rdy_after;

        a       = int'(a6);
        err     = (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0);
        n       = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        exp_rd  = (!we && !err) ? ref_load(a, n, uns) : 32'h0;
        exp_wd  = 32'h0;
        if (we && !err) begin
            for (int i = 0; i < n; i++) ref_b[a + i] = 8'(wd >> (8 * i));
            exp_wd = ref_word(a);
        end
        exp_lat = err ? 1 : !we ? 2 : (sz == 2'd2) ? 1 : 3;
        exp_re  = (err || (we && sz == 2'd2)) ? 0 : 1;
        exp_we  = (we && !err) ? 1 : 0;

        chk("ready_before_req", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = 32'(a6); req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_we = $urandom_range(0, 1); req_size = 2'($urandom);
        req_unsigned = $urandom_range(0, 1); req_addr = $urandom; req_wdata = $urandom;

        lat = 0; extra = 0; re_cnt = 0; we_cnt = 0; both = 0; idle_nz = 0;
        got_rd = 32'h0; got_wd = 32'h0; got_wa = 32'h0; got_ra = 32'h0;
        got_err = 1'b0; rdy_at_rsp = 1'b1; rdy_after = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (mem_re) begin re_cnt++; got_ra = mem_addr; end
            if (mem_we) begin we_cnt++; got_wd = mem_wdata; got_wa = mem_addr; end
            if (mem_re && mem_we) both++;
            if (rsp_valid) begin
                if (lat == 0) lat = c; else extra++;
                got_rd = rsp_rdata; got_err = rsp_err; rdy_at_rsp = req_ready;
            end else if (rsp_rdata !== 32'h0) begin
                idle_nz++;
            end
            if (lat != 0 && c == lat + 1) rdy_after = req_ready;
        end

        chk("rsp_latency", 32'(lat), 32'(exp_lat));
        chk("rsp_extra_pulses", 32'(extra), 32'd0);
        chk("mem_re_cycles", 32'(re_cnt), 32'(exp_re));
        chk("mem_we_cycles", 32'(we_cnt), 32'(exp_we));
        chk("re_we_overlap", 32'(both), 32'd0);
        chk("rsp_rdata", got_rd, exp_rd);
        chk("rsp_err", 32'(got_err), 32'(err));
        chk("rdata_zero_when_idle", 32'(idle_nz), 32'd0);
        chk("ready_low_at_rsp", 32'(rdy_at_rsp), 32'd0);
        chk("ready_after_rsp", 32'(rdy_after), 32'd1);
        if (exp_re == 1) chk("read_addr", got_ra, 32'(a - a % 4));
        if (exp_we == 1) begin
            chk("write_data", got_wd, exp_wd);
            chk("write_addr", got_wa, 32'(a - a % 4));
        end
        last_rdata = got_rd; last_wdata = got_wd; last_waddr = got_wa;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;
        for (int i = 0; i < 16; i++) begin
            w = (i == 4) ? 32'h8899AABB : $urandom;
            mem[i] = w;
            for (int b = 0; b < 4; b++) ref_b[4 * i + b] = 8'(w >> (8 * b));
        end
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        repeat (2) @(negedge clk);
        chk("reset_req_ready", 32'(req_ready), 32'd1);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_err", 32'(rsp_err), 32'd0);
        chk("reset_mem_strobes", {30'd0, mem_we, mem_re}, 32'd0);
        chk("reset_rsp_rdata", rsp_rdata, 32'h0);
        chk("reset_mem_addr", mem_addr, 32'h0);
        chk("reset_mem_wdata", mem_wdata, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        do_req(1'b0, 2'd2, 1'b0, 6'h10, 32'h0);  chk("lw_10", last_rdata, 32'h8899AABB);
        do_req(1'b0, 2'd0, 1'b0, 6'h13, 32'h0);  chk("lb_13", last_rdata, 32'hFFFFFF88);
        do_req(1'b0, 2'd0, 1'b1, 6'h11, 32'h0);  chk("lbu_11", last_rdata, 32'h000000AA);
        do_req(1'b0, 2'd1, 1'b0, 6'h12, 32'h0);  chk("lh_12", last_rdata, 32'hFFFF8899);
        do_req(1'b0, 2'd1, 1'b1, 6'h10, 32'h0);  chk("lhu_10", last_rdata, 32'h0000AABB);
        do_req(1'b1, 2'd0, 1'b0, 6'h11, 32'h123456CC);
        chk("sb_11_merge", last_wdata, 32'h8899CCBB);
        do_req(1'b0, 2'd2, 1'b0, 6'h10, 32'h0);  chk("lw_10_after_sb", last_rdata, 32'h8899CCBB);
        do_req(1'b1, 2'd2, 1'b0, 6'h14, 32'hDEADBEEF);
        chk("sw_14_addr", last_waddr, 32'h14);
        chk("sw_14_data", last_wdata, 32'hDEADBEEF);
        do_req(1'b0, 2'd1, 1'b0, 6'h11, 32'h0);
        do_req(1'b1, 2'd2, 1'b0, 6'h16, 32'h0);
        do_req(1'b0, 2'd3, 1'b0, 6'h08, 32'h0);

        // SH 0x12 abandoned by reset in MERGE; reference memory deliberately left untouched.
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd1; req_unsigned = 1'b0;
        req_addr = 32'h12; req_wdata = 32'h0000BEEF;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk); seen_we = mem_we;
        chk("abort_rd_strobe", 32'(mem_re), 32'd1);
        @(negedge clk); seen_we = seen_we | mem_we;
        rst_n = 1'b0;
        #1;
        chk("abort_ready_immediate", 32'(req_ready), 32'd1);
        chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("abort_mem_we", 32'(mem_we), 32'd0);
        @(negedge clk); seen_we = seen_we | mem_we;
        rst_n = 1'b1;
        @(negedge clk); seen_we = seen_we | mem_we;
        chk("abort_no_write", 32'(seen_we), 32'd0);
        chk("abort_word_unchanged", mem[4], ref_word(16));
        do_req(1'b0, 2'd2, 1'b0, 6'h10, 32'h0);  chk("lw_10_after_abort", last_rdata, 32'h8899CCBB);

        for (int t = 0; t < 60; t++) begin
            do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   6'($urandom_range(0, 63)), $urandom);
        end
        for (int i = 0; i < 16; i++) chk("final_mem_word", mem[i], ref_word(4 * i));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
